// File: rtl/one_conv_ifm_tile_seq.sv
// IFM tile sequencer for 1x1 conv: walks channel -> column tile -> row -> ofm group, one beat per fire.
// Latency: start -> CALC (n_tiles cycles) -> RUN; done pulses the cycle after the final fire.
// Backpressure: beat_ready is high only in RUN; indices hold whenever beat_valid is low.
// Optional macro ONE_CONV_SEQ_PERF_EN adds a saturating 32-bit stall counter output perf_stall.
module one_conv_ifm_tile_seq #(
    parameter int TILE_W  = 13,
    parameter int W_BITS  = 9,
    parameter int C_BITS  = 11,
    parameter int OFM_PAR = 1,
    localparam int TP_BITS = ($clog2(TILE_W + 1) > 5) ? $clog2(TILE_W + 1) : 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W_BITS-1:0]  cfg_width,
    input  logic [W_BITS-1:0]  cfg_height,
    input  logic [C_BITS-1:0]  cfg_ifm_ch,
    input  logic [C_BITS-1:0]  cfg_ofm_ch,
    input  logic               beat_valid,
    output logic               beat_ready,
    output logic [C_BITS-1:0]  c_idx,
    output logic [W_BITS-1:0]  t_idx,
    output logic [W_BITS-1:0]  h_idx,
    output logic [C_BITS-1:0]  og_idx,
    output logic [W_BITS-1:0]  n_tiles,
    output logic [TP_BITS-1:0] tile_pixels,
    output logic [W_BITS-1:0]  tiles_remain,
    output logic               last_chan,
    output logic               last_tile,
    output logic               last_row,
    output logic               last_og,
    output logic               busy,
    output logic               done,
`ifdef ONE_CONV_SEQ_PERF_EN
    output logic               cfg_err,
    output logic [31:0]        perf_stall
`else
    output logic               cfg_err
`endif
);

    localparam int                 OG_SH    = $clog2(OFM_PAR);
    localparam logic [W_BITS-1:0]  TILE_WW  = W_BITS'(TILE_W);
    localparam logic [TP_BITS-1:0] TILE_WTP = TP_BITS'(TILE_W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN, S_DONE} state_t;

    state_t              state_q;
    logic [W_BITS-1:0]   cfg_width_q, cfg_height_q;
    logic [C_BITS-1:0]   cfg_ifm_q, cfg_ofm_q;
    logic [W_BITS-1:0]   rem_q;
    logic [W_BITS-1:0]   n_tiles_q;
    logic [TP_BITS-1:0]  tail_q;
    logic [C_BITS-1:0]   c_idx_q, og_idx_q;
    logic [W_BITS-1:0]   t_idx_q, h_idx_q;
    logic [C_BITS-1:0]   c_idx_d, og_idx_d;
    logic [W_BITS-1:0]   t_idx_d, h_idx_d;
    logic                cfg_err_q;
    logic [C_BITS:0]     n_og;
    logic                fire;
    logic                all_last;
    logic                cfg_zero;

    // ofm group count: round up to whole groups of OFM_PAR channels
    assign n_og = ({1'b0, cfg_ofm_q} + (C_BITS + 1)'(OFM_PAR - 1)) >> OG_SH;

    assign last_chan = (c_idx_q == cfg_ifm_q - C_BITS'(1));
    assign last_tile = (t_idx_q == n_tiles_q - W_BITS'(1));
    assign last_row  = (h_idx_q == cfg_height_q - W_BITS'(1));
    assign last_og   = ({1'b0, og_idx_q} == n_og - (C_BITS + 1)'(1));
    assign all_last  = last_chan & last_tile & last_row & last_og;

    assign fire     = beat_valid & (state_q == S_RUN);
    assign cfg_zero = (cfg_width == '0) | (cfg_height == '0) |
                      (cfg_ifm_ch == '0) | (cfg_ofm_ch == '0);

    // odometer advance: each index wraps to 0 and carries into the next one
    always_comb begin
        c_idx_d  = c_idx_q;
        t_idx_d  = t_idx_q;
        h_idx_d  = h_idx_q;
        og_idx_d = og_idx_q;
        if (!last_chan) begin
            c_idx_d = c_idx_q + C_BITS'(1);
        end else begin
            c_idx_d = '0;
            if (!last_tile) begin
                t_idx_d = t_idx_q + W_BITS'(1);
            end else begin
                t_idx_d = '0;
                if (!last_row) begin
                    h_idx_d = h_idx_q + W_BITS'(1);
                end else begin
                    h_idx_d  = '0;
                    og_idx_d = last_og ? '0 : og_idx_q + C_BITS'(1);
                end
            end
        end
    end

    // main sequencer: config latch, tile-count division by repeated subtraction, beat walk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_width_q  <= '0;
            cfg_height_q <= '0;
            cfg_ifm_q    <= '0;
            cfg_ofm_q    <= '0;
            rem_q        <= '0;
            n_tiles_q    <= W_BITS'(1);
            tail_q       <= '0;
            c_idx_q      <= '0;
            t_idx_q      <= '0;
            h_idx_q      <= '0;
            og_idx_q     <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_width_q  <= cfg_width;
                        cfg_height_q <= cfg_height;
                        cfg_ifm_q    <= cfg_ifm_ch;
                        cfg_ofm_q    <= cfg_ofm_ch;
                        c_idx_q      <= '0;
                        t_idx_q      <= '0;
                        h_idx_q      <= '0;
                        og_idx_q     <= '0;
                        if (cfg_zero) begin
                            cfg_err_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            cfg_err_q <= 1'b0;
                            rem_q     <= cfg_width;
                            n_tiles_q <= W_BITS'(1);
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (rem_q > TILE_WW) begin
                        rem_q     <= rem_q - TILE_WW;
                        n_tiles_q <= n_tiles_q + W_BITS'(1);
                    end else begin
                        tail_q  <= TP_BITS'(rem_q);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        c_idx_q  <= c_idx_d;
                        t_idx_q  <= t_idx_d;
                        h_idx_q  <= h_idx_d;
                        og_idx_q <= og_idx_d;
                        if (all_last) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ONE_CONV_SEQ_PERF_EN
    logic [31:0] perf_stall_q;

    // count RUN cycles with no upstream data; saturating, cleared on an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            perf_stall_q <= '0;
        end else if (state_q == S_RUN && !beat_valid && perf_stall_q != '1) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_stall = perf_stall_q;
`endif

    assign beat_ready   = (state_q == S_RUN);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;
    assign c_idx        = c_idx_q;
    assign t_idx        = t_idx_q;
    assign h_idx        = h_idx_q;
    assign og_idx       = og_idx_q;
    assign n_tiles      = n_tiles_q;
    assign tile_pixels  = last_tile ? tail_q : TILE_WTP;
    assign tiles_remain = n_tiles_q - W_BITS'(1) - t_idx_q;

endmodule

// File: tb/tb_one_conv_ifm_tile_seq.sv
// Scoreboard bench for one_conv_ifm_tile_seq: stimulus pushes expected beats, a monitor pops on each fire.
// Directed frames cover partial/exact tiles, stalls, config errors and mid-frame reset.
// Build with ONE_CONV_SEQ_PERF_EN defined to also check the stall counter.
module tb_one_conv_ifm_tile_seq;

    localparam int TILE_W = 13;
    localparam int W_BITS = 9;
    localparam int C_BITS = 11;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [W_BITS-1:0] cfg_width, cfg_height;
    logic [C_BITS-1:0] cfg_ifm_ch, cfg_ofm_ch;
    logic              beat_valid;
    logic              beat_ready;
    logic [C_BITS-1:0] c_idx, og_idx;
    logic [W_BITS-1:0] t_idx, h_idx, n_tiles, tiles_remain;
    logic [4:0]        tile_pixels;
    logic              last_chan, last_tile, last_row, last_og;
    logic              busy, done, cfg_err;
`ifdef ONE_CONV_SEQ_PERF_EN
    logic [31:0]       perf_stall;
`endif

    one_conv_ifm_tile_seq #(
        .TILE_W(TILE_W), .W_BITS(W_BITS), .C_BITS(C_BITS), .OFM_PAR(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_ifm_ch(cfg_ifm_ch), .cfg_ofm_ch(cfg_ofm_ch),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .c_idx(c_idx), .t_idx(t_idx), .h_idx(h_idx), .og_idx(og_idx),
        .n_tiles(n_tiles), .tile_pixels(tile_pixels), .tiles_remain(tiles_remain),
        .last_chan(last_chan), .last_tile(last_tile), .last_row(last_row), .last_og(last_og),
        .busy(busy), .done(done),
`ifdef ONE_CONV_SEQ_PERF_EN
        .cfg_err(cfg_err), .perf_stall(perf_stall)
`else
        .cfg_err(cfg_err)
`endif
    );

    typedef struct {
        int c, t, h, og, tp, tr;
        bit lc, lt, lh, lo;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    // monitor: every accepted beat must match the next expected beat
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && beat_valid && beat_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("c_idx", c_idx, e.c);
                chk("t_idx", t_idx, e.t);
                chk("h_idx", h_idx, e.h);
                chk("og_idx", og_idx, e.og);
                chk("tile_pixels", tile_pixels, e.tp);
                chk("tiles_remain", tiles_remain, e.tr);
                chk("last_flags", {last_chan, last_tile, last_row, last_og},
                    {e.lc, e.lt, e.lh, e.lo});
            end
        end
    end

    // one layer; exp_nt and tail are hand-computed; rst_at>0 asserts reset on that fire
    task automatic run_frame(input int w, input int h, input int ic, input int oc,
                             input int exp_nt, input int tail, input bit stall, input int rst_at);
        beat_t b;
        int    total, calc_cnt, run_cyc, nf;
        bit    seen_rdy, got_done, prev_fire, got_rst;
        total = ic * exp_nt * h * oc;
        for (int og = 0; og < oc; og++)
            for (int hh = 0; hh < h; hh++)
                for (int t = 0; t < exp_nt; t++)
                    for (int c = 0; c < ic; c++) begin
                        b.c = c; b.t = t; b.h = hh; b.og = og;
                        b.tp = (t == exp_nt - 1) ? tail : TILE_W;
                        b.tr = exp_nt - 1 - t;
                        b.lc = (c == ic - 1); b.lt = (t == exp_nt - 1);
                        b.lh = (hh == h - 1); b.lo = (og == oc - 1);
                        exp_q.push_back(b);
                    end
        @(posedge clk); #1;
        cfg_width = W_BITS'(w); cfg_height = W_BITS'(h);
        cfg_ifm_ch = C_BITS'(ic); cfg_ofm_ch = C_BITS'(oc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cfg_err_after_start", cfg_err, 0);
        calc_cnt = 0; run_cyc = 0; nf = 0;
        seen_rdy = 0; got_done = 0; prev_fire = 0; got_rst = 0;
        for (int cyc = 0; cyc < 3000 && !got_done && !got_rst; cyc++) begin
            if (beat_ready) begin
                if (!seen_rdy) begin
                    seen_rdy = 1;
                    chk("calc_cycles", calc_cnt, exp_nt);
                    chk("n_tiles", n_tiles, exp_nt);
                end
                beat_valid = stall ? (run_cyc % 2 == 0) : 1'b1;
                run_cyc++;
                if (rst_at > 0 && nf == rst_at - 1 && beat_valid) rst_n = 1'b0;
            end else begin
                if (!seen_rdy) calc_cnt++;
                beat_valid = !stall;
            end
            @(negedge clk);
            if (!rst_n) begin
                got_rst = 1;
            end else begin
                if (done) begin
                    got_done = 1;
                    chk("done_after_last_fire", prev_fire, 1);
                    chk("fire_count", nf, total);
                end
                prev_fire = beat_valid && beat_ready;
                if (prev_fire) nf++;
                @(posedge clk); #1;
            end
        end
        if (got_rst) begin
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_ready", beat_ready, 0);
            chk("rst_done", done, 0);
            chk("rst_indices", {c_idx, t_idx, h_idx, og_idx}, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            beat_valid = 1'b0;
            @(posedge clk); #1;
            chk("rst_no_done", done, 0);
            chk("rst_remaining_beats", exp_q.size(), total - (rst_at - 1));
            exp_q.delete();
        end else begin
            if (!got_done) chk("done_timeout", 0, 1);
            chk("queue_empty", exp_q.size(), 0);
            beat_valid = 1'b0;
            chk("done_single_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_indices", {c_idx, t_idx, h_idx, og_idx}, 0);
`ifdef ONE_CONV_SEQ_PERF_EN
            chk("perf_stall", perf_stall, stall ? total - 1 : 0);
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; beat_valid = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_ifm_ch = '0; cfg_ofm_ch = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", beat_ready, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_n_tiles", n_tiles, 1);
        chk("reset_indices", {c_idx, t_idx, h_idx, og_idx}, 0);
        rst_n = 1'b1;

        run_frame(416, 1, 1, 1, 32, 13, 0, 0);
        run_frame(30,  1, 1, 1, 3,  4,  0, 0);
        run_frame(26,  2, 3, 2, 2,  13, 0, 0);
        run_frame(26,  2, 3, 2, 2,  13, 1, 0);
        run_frame(13,  1, 2, 1, 1,  13, 0, 0);

        // zero channel count: error flag and immediate done, no beats accepted
        @(posedge clk); #1;
        cfg_width = 9'd26; cfg_height = 9'd2; cfg_ifm_ch = '0; cfg_ofm_ch = 11'd2;
        start = 1'b1; beat_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_done", done, 1);
        chk("err_flag", cfg_err, 1);
        chk("err_ready", beat_ready, 0);
        @(posedge clk); #1;
        chk("err_done_cleared", done, 0);
        chk("err_idle", busy, 0);
        chk("err_sticky", cfg_err, 1);
        beat_valid = 1'b0;
        run_frame(5, 2, 1, 3, 1, 5, 0, 0);

        run_frame(26, 2, 3, 2, 2, 13, 0, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
